// File: rtl/nx_token_ctrl.sv
// Column token controller: one circulating send-token per mesh column, with a
// minimum re-issue gap, lost-token detection and sticky error flags.
module nx_token_ctrl #(
  parameter int unsigned COLUMNS     = 3,
  parameter int unsigned MIN_GAP     = 2,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   clear_i,
  output logic [COLUMNS-1:0]     token_grant_o,
  input  logic [COLUMNS-1:0]     token_release_i,
  output logic                   tokens_home_o,
  output logic [COLUMNS-1:0]     timeout_o,
  output logic [COLUMNS-1:0]     spurious_o,
  output logic [COUNT_WIDTH-1:0] lap_count_o
);

  localparam int unsigned GapW    = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam int unsigned FlightW = $clog2(TIMEOUT);
  localparam int unsigned PopW    = $clog2(COLUMNS + 1);
  localparam int unsigned SumW    = COUNT_WIDTH + PopW;

  localparam logic [GapW-1:0]    GapMax    = GapW'(MIN_GAP);
  localparam logic [FlightW-1:0] FlightMax = FlightW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StHome, StFlight, StLost} state_e;

  state_e               state_q  [COLUMNS];
  state_e               state_d  [COLUMNS];
  logic [GapW-1:0]      gap_q    [COLUMNS];
  logic [GapW-1:0]      gap_d    [COLUMNS];
  logic [FlightW-1:0]   flight_q [COLUMNS];
  logic [FlightW-1:0]   flight_d [COLUMNS];

  logic [COLUMNS-1:0]     grant_d, grant_q;
  logic [COLUMNS-1:0]     timeout_d, timeout_q, timeout_set;
  logic [COLUMNS-1:0]     spurious_d, spurious_q, spurious_set;
  logic [COLUMNS-1:0]     ret;
  logic [PopW-1:0]        pop;
  logic [COUNT_WIDTH-1:0] lap_base, lap_d, lap_q;
  logic [SumW-1:0]        lap_sum;

  always_comb begin
    grant_d      = '0;
    timeout_set  = '0;
    spurious_set = '0;
    ret          = '0;
    for (int unsigned c = 0; c < COLUMNS; c++) begin
      state_d[c]  = state_q[c];
      gap_d[c]    = gap_q[c];
      flight_d[c] = flight_q[c];
      unique case (state_q[c])
        StHome: begin
          if (gap_q[c] < GapMax) gap_d[c] = gap_q[c] + 1'b1;
          if (token_release_i[c]) spurious_set[c] = 1'b1;
          if (enable_i && (gap_q[c] >= GapMax)) begin
            state_d[c]  = StFlight;
            grant_d[c]  = 1'b1;
            flight_d[c] = '0;
          end
        end
        StFlight: begin
          // A return on the last in-flight cycle beats the timeout.
          if (token_release_i[c]) begin
            state_d[c] = StHome;
            gap_d[c]   = '0;
            ret[c]     = 1'b1;
          end else if (flight_q[c] == FlightMax) begin
            state_d[c]     = StLost;
            timeout_set[c] = 1'b1;
          end else begin
            flight_d[c] = flight_q[c] + 1'b1;
          end
        end
        StLost: begin
          if (token_release_i[c]) begin
            state_d[c] = StHome;
            gap_d[c]   = '0;
            ret[c]     = 1'b1;
          end else if (clear_i) begin
            state_d[c] = StHome;
            gap_d[c]   = '0;
          end
        end
        default: state_d[c] = StHome;
      endcase
    end
  end

  // Clear is applied first so same-cycle events survive it.
  always_comb begin
    timeout_d  = (clear_i ? '0 : timeout_q) | timeout_set;
    spurious_d = (clear_i ? '0 : spurious_q) | spurious_set;
    pop = '0;
    for (int unsigned c = 0; c < COLUMNS; c++) pop = pop + PopW'(ret[c]);
    lap_base = clear_i ? '0 : lap_q;
    lap_sum  = {{PopW{1'b0}}, lap_base} + SumW'(pop);
    lap_d    = (lap_sum[SumW-1:COUNT_WIDTH] != '0) ? '1 : lap_sum[COUNT_WIDTH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < COLUMNS; c++) begin
        state_q[c]  <= StHome;
        gap_q[c]    <= GapMax;
        flight_q[c] <= '0;
      end
      grant_q    <= '0;
      timeout_q  <= '0;
      spurious_q <= '0;
      lap_q      <= '0;
    end else begin
      for (int unsigned c = 0; c < COLUMNS; c++) begin
        state_q[c]  <= state_d[c];
        gap_q[c]    <= gap_d[c];
        flight_q[c] <= flight_d[c];
      end
      grant_q    <= grant_d;
      timeout_q  <= timeout_d;
      spurious_q <= spurious_d;
      lap_q      <= lap_d;
    end
  end

  always_comb begin
    tokens_home_o = 1'b1;
    for (int unsigned c = 0; c < COLUMNS; c++) begin
      if (state_q[c] != StHome) tokens_home_o = 1'b0;
    end
  end

  assign token_grant_o = grant_q;
  assign timeout_o     = timeout_q;
  assign spurious_o    = spurious_q;
  assign lap_count_o   = lap_q;

endmodule

// File: tb/tb_nx_token_ctrl.sv
// Directed bench for nx_token_ctrl (COLUMNS=3, MIN_GAP=2, TIMEOUT=8).
module tb_nx_token_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [2:0]  token_grant_o;
  logic [2:0]  token_release_i = '0;
  logic        tokens_home_o;
  logic [2:0]  timeout_o;
  logic [2:0]  spurious_o;
  logic [15:0] lap_count_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  nx_token_ctrl #(
    .COLUMNS(3), .MIN_GAP(2), .TIMEOUT(8), .COUNT_WIDTH(16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .clear_i         (clear_i),
    .token_grant_o   (token_grant_o),
    .token_release_i (token_release_i),
    .tokens_home_o   (tokens_home_o),
    .timeout_o       (timeout_o),
    .spurious_o      (spurious_o),
    .lap_count_o     (lap_count_o)
  );

  always #5 clk = ~clk;

  // Values read after step() belong to cycle cyc; inputs set then are sampled at its end.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; token_release_i = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;
    cyc = 0;
  endtask

  task automatic pulse_release(input logic [2:0] r);
    token_release_i = r;
    step();
    token_release_i = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; enable_i = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (token_grant_o !== 3'b000) begin n_fail++;
      $display("FAIL reset_grant: got %b want 000", token_grant_o); end
    n_checks++; if (timeout_o !== 3'b000) begin n_fail++;
      $display("FAIL reset_timeout: got %b want 000", timeout_o); end
    n_checks++; if (spurious_o !== 3'b000) begin n_fail++;
      $display("FAIL reset_spurious: got %b want 000", spurious_o); end
    n_checks++; if (lap_count_o !== 16'd0) begin n_fail++;
      $display("FAIL reset_lap: got %0d want 0", lap_count_o); end
    n_checks++; if (tokens_home_o !== 1'b1) begin n_fail++;
      $display("FAIL reset_home: got %b want 1", tokens_home_o); end
  endtask

  task automatic test_startup();
    do_reset();
    enable_i = 1'b1;
    n_checks++; if (token_grant_o !== 3'b000 || tokens_home_o !== 1'b1) begin n_fail++;
      $display("FAIL start_c0: grant %b home %b want 000/1", token_grant_o, tokens_home_o); end
    step();
    n_checks++; if (token_grant_o !== 3'b111) begin n_fail++;
      $display("FAIL start_grant: got %b want 111", token_grant_o); end
    n_checks++; if (tokens_home_o !== 1'b0) begin n_fail++;
      $display("FAIL start_home: got %b want 0", tokens_home_o); end
    step();
    n_checks++; if (token_grant_o !== 3'b000) begin n_fail++;
      $display("FAIL start_pulse: got %b want 000", token_grant_o); end
  endtask

  task automatic test_gap();
    do_reset();
    enable_i = 1'b1;
    go_to(4);
    pulse_release(3'b001);
    n_checks++; if (lap_count_o !== 16'd1) begin n_fail++;
      $display("FAIL gap_lap: got %0d want 1", lap_count_o); end
    go_to(7);
    n_checks++; if (token_grant_o !== 3'b000) begin n_fail++;
      $display("FAIL gap_early: got %b want 000", token_grant_o); end
    step();
    n_checks++; if (token_grant_o !== 3'b001) begin n_fail++;
      $display("FAIL gap_regrant: got %b want 001", token_grant_o); end
  endtask

  task automatic test_timeout_regen();
    do_reset();
    enable_i = 1'b1;
    go_to(4);
    pulse_release(3'b011);
    go_to(9);
    n_checks++; if (timeout_o !== 3'b100) begin n_fail++;
      $display("FAIL to_flag: got %b want 100", timeout_o); end
    go_to(12);
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    n_checks++; if (timeout_o !== 3'b000) begin n_fail++;
      $display("FAIL to_clear: got %b want 000", timeout_o); end
    go_to(15);
    n_checks++; if (token_grant_o[2] !== 1'b0) begin n_fail++;
      $display("FAIL to_regen_early: got %b want 0", token_grant_o[2]); end
    step();
    n_checks++; if (token_grant_o[2] !== 1'b1) begin n_fail++;
      $display("FAIL to_regen: got %b want 1", token_grant_o[2]); end
    n_checks++; if (timeout_o !== 3'b011) begin n_fail++;
      $display("FAIL to_second: got %b want 011", timeout_o); end
  endtask

  task automatic test_late_return();
    do_reset();
    enable_i = 1'b1;
    go_to(4);
    pulse_release(3'b101);
    go_to(9);
    n_checks++; if (timeout_o !== 3'b010) begin n_fail++;
      $display("FAIL late_lost: got %b want 010", timeout_o); end
    go_to(11);
    pulse_release(3'b010);
    n_checks++; if (lap_count_o !== 16'd3) begin n_fail++;
      $display("FAIL late_lap: got %0d want 3", lap_count_o); end
    n_checks++; if (timeout_o[1] !== 1'b1) begin n_fail++;
      $display("FAIL late_sticky: got %b want 1", timeout_o[1]); end
    go_to(14);
    n_checks++; if (token_grant_o[1] !== 1'b0) begin n_fail++;
      $display("FAIL late_early: got %b want 0", token_grant_o[1]); end
    step();
    n_checks++; if (token_grant_o[1] !== 1'b1) begin n_fail++;
      $display("FAIL late_regrant: got %b want 1", token_grant_o[1]); end
  endtask

  task automatic test_race();
    do_reset();
    enable_i = 1'b1;
    go_to(8);
    pulse_release(3'b001);
    n_checks++; if (timeout_o !== 3'b110) begin n_fail++;
      $display("FAIL race_timeout: got %b want 110", timeout_o); end
    n_checks++; if (lap_count_o !== 16'd1) begin n_fail++;
      $display("FAIL race_lap: got %0d want 1", lap_count_o); end
    go_to(12);
    n_checks++; if (token_grant_o !== 3'b001) begin n_fail++;
      $display("FAIL race_regrant: got %b want 001", token_grant_o); end
  endtask

  task automatic test_drain_spurious();
    do_reset();
    enable_i = 1'b1;
    go_to(2);
    enable_i = 1'b0;
    go_to(5);
    pulse_release(3'b111);
    n_checks++; if (tokens_home_o !== 1'b1) begin n_fail++;
      $display("FAIL drain_home: got %b want 1", tokens_home_o); end
    n_checks++; if (lap_count_o !== 16'd3) begin n_fail++;
      $display("FAIL drain_lap: got %0d want 3", lap_count_o); end
    go_to(7);
    pulse_release(3'b001);
    n_checks++; if (spurious_o !== 3'b001) begin n_fail++;
      $display("FAIL spur_flag: got %b want 001", spurious_o); end
    n_checks++; if (lap_count_o !== 16'd3) begin n_fail++;
      $display("FAIL spur_lap: got %0d want 3", lap_count_o); end
    // Clear and a new spurious release together: the new flag survives.
    clear_i = 1'b1;
    pulse_release(3'b010);
    clear_i = 1'b0;
    n_checks++; if (spurious_o !== 3'b010) begin n_fail++;
      $display("FAIL spur_clear: got %b want 010", spurious_o); end
    n_checks++; if (lap_count_o !== 16'd0) begin n_fail++;
      $display("FAIL lap_clear: got %0d want 0", lap_count_o); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (token_grant_o !== 3'b000 || tokens_home_o !== 1'b1) begin n_fail++;
        $display("FAIL drain_idle: grant %b home %b want 000/1", token_grant_o, tokens_home_o);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_gap();
    test_timeout_regen();
    test_late_return();
    test_race();
    test_drain_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
